// File: rtl/sdm_pkg.sv
// Shared constants, mode encoding and the saturation helper for the multi-channel
// sigma-delta modulator.
package sdm_pkg;

  localparam logic [15:0] LFSR_POLY = 16'hB400;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  typedef enum logic {
    MODE_1ST = 1'b0,
    MODE_2ND = 1'b1
  } mode_e;

  typedef struct packed {
    logic signed [31:0] val;
    logic               clamp;
  } sat_t;

  // Symmetric clamp to +/-(2^(gw-1)-1); the flag feeds the sticky overflow bit.
  function automatic sat_t sat(input logic signed [31:0] v, input int gw);
    logic signed [31:0] lim;
    sat_t               r;
    lim     = (32'sd1 <<< (gw - 1)) - 32'sd1;
    r.val   = v;
    r.clamp = 1'b0;
    if (v > lim) begin
      r.val   = lim;
      r.clamp = 1'b1;
    end else if (v < -lim) begin
      r.val   = -lim;
      r.clamp = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sdm_mc_chan.sv
// One modulator channel: 1st-order accumulator or 2nd-order saturating integrator
// pair, registered output bit and sticky overflow flag.
module sdm_mc_chan
  import sdm_pkg::*;
#(
  parameter int W  = 12,
  parameter int GW = W + 4,
  parameter int D  = 2
) (
  input  logic         clk_fast,
  input  logic         rst,
  input  logic         en,
  input  mode_e        mode_r,
  input  logic         mode_chg,
  input  logic         dither_en,
  input  logic         ovf_clr,
  input  logic [W-1:0] s,
  input  logic [D-1:0] lfsr_bits,
  output logic         dout,
  output logic         ovf
);

  localparam int H    = 1 << (W - 1);
  localparam int DOFF = 1 << (D - 1);

  // Only the low W bits of the 1st-order accumulator persist; its carry lives in dout.
  logic [W-1:0]        acc;
  logic [W:0]          acc_n;
  logic signed [GW-1:0] i1, i2;
  logic signed [31:0]  x, fb, d;
  sat_t                i1s, i2s;
  logic                unused_hi;

  // NOTE: every signal written in always_comb is given a value first, so no latch can form.
  always_comb begin
    acc_n = {1'b0, s} + {1'b0, acc};
    x     = 32'(s) - H;
    fb    = dout ? H : -H;
    d     = dither_en ? 32'(lfsr_bits) - DOFF : '0;
    i1s   = sat(32'(i1) + x + d - fb, GW);
    i2s   = sat(32'(i2) + i1s.val - fb, GW);
  end

  assign unused_hi = ^{i1s.val[31:GW], i2s.val[30:GW]};

  // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk_fast) begin
    if (rst) begin
      acc  <= '0;
      i1   <= '0;
      i2   <= '0;
      dout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (ovf_clr) ovf <= 1'b0;
      if (en) begin
        if (mode_chg) begin
          acc  <= '0;
          i1   <= '0;
          i2   <= '0;
          dout <= 1'b0;
        end else if (mode_r == MODE_1ST) begin
          acc  <= acc_n[W-1:0];
          dout <= acc_n[W];
        end else begin
          i1   <= i1s.val[GW-1:0];
          i2   <= i2s.val[GW-1:0];
          dout <= ~i2s.val[31];
          // Written after the clear so a clamp in the same cycle wins.
          if (i1s.clamp || i2s.clamp) ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sdm_mc.sv
// Multi-channel sigma-delta modulator top: shadow/active sample banks with a
// valid/ready handshake, mode register, shared dither LFSR and per-channel datapaths.
module sdm_mc
  import sdm_pkg::*;
#(
  parameter int W  = 12,
  parameter int CH = 2,
  parameter int GW = W + 4,
  parameter int D  = 2
) (
  input  logic            clk_fast,
  input  logic            rst,
  input  logic            en,
  input  logic            din_valid,
  output logic            din_ready,
  input  logic [CH*W-1:0] din,
  input  logic            mode,
  input  logic            dither_en,
  input  logic            ovf_clr,
  output logic [CH-1:0]   dout,
  output logic [CH-1:0]   ovf
);

  localparam logic [W-1:0] HALF = {1'b1, {(W-1){1'b0}}};

  logic [CH*W-1:0] shadow, active;
  logic            shadow_full, accept, mode_chg;
  mode_e           mode_r;
  logic [15:0]     lfsr;

  // A tick empties the shadow, so it can take a new bank in the same cycle.
  assign din_ready = ~shadow_full | en;
  assign accept    = din_valid & din_ready;
  assign mode_chg  = (mode != mode_r);

  always_ff @(posedge clk_fast) begin
    if (rst) begin
      shadow      <= '0;
      shadow_full <= 1'b0;
      active      <= {CH{HALF}};
      mode_r      <= MODE_1ST;
      lfsr        <= LFSR_SEED;
    end else begin
      if (en) begin
        if (shadow_full) active <= shadow;
        if (mode_chg) mode_r <= mode_e'(mode);
        lfsr <= lfsr[0] ? ((lfsr >> 1) ^ LFSR_POLY) : (lfsr >> 1);
      end
      if (accept) begin
        shadow      <= din;
        shadow_full <= 1'b1;
      end else if (en) begin
        shadow_full <= 1'b0;
      end
    end
  end

  for (genvar c = 0; c < CH; c++) begin : g_chan
    sdm_mc_chan #(.W(W), .GW(GW), .D(D)) u_chan (
      .clk_fast  (clk_fast),
      .rst       (rst),
      .en        (en),
      .mode_r    (mode_r),
      .mode_chg  (mode_chg),
      .dither_en (dither_en),
      .ovf_clr   (ovf_clr),
      .s         (active[c*W +: W]),
      .lfsr_bits (lfsr[c*D +: D]),
      .dout      (dout[c]),
      .ovf       (ovf[c])
    );
  end

endmodule

// File: tb/tb_sdm_mc.sv
// Scoreboard bench for sdm_mc: the driver pushes reference-model expectations per tick,
// a negedge monitor pops and compares them; directed checks cover the hand-computed cases.
`timescale 1ns/1ps
module tb_sdm_mc;
  localparam int W   = 12;
  localparam int CH  = 2;
  localparam int GW  = 16;
  localparam int D   = 2;
  localparam int H   = 2048;
  localparam int LIM = 32767;

  logic            clk_fast = 1'b0;
  logic            rst, en, din_valid, mode, dither_en, ovf_clr;
  logic [CH*W-1:0] din;
  logic            din_ready, din_ready_g;
  logic [CH-1:0]   dout, ovf, dout_g, ovf_g;

  always #5 clk_fast = ~clk_fast;

  sdm_mc #(.W(W), .CH(CH), .GW(GW), .D(D)) dut (
    .clk_fast(clk_fast), .rst(rst), .en(en), .din_valid(din_valid), .din_ready(din_ready),
    .din(din), .mode(mode), .dither_en(dither_en), .ovf_clr(ovf_clr), .dout(dout), .ovf(ovf)
  );

  // Narrow-integrator copy sharing all inputs, used for the saturation scenario.
  sdm_mc #(.W(W), .CH(CH), .GW(W + 1), .D(D)) dut_g (
    .clk_fast(clk_fast), .rst(rst), .en(en), .din_valid(din_valid), .din_ready(din_ready_g),
    .din(din), .mode(mode), .dither_en(dither_en), .ovf_clr(ovf_clr), .dout(dout_g), .ovf(ovf_g)
  );

  typedef struct packed {
    logic [CH-1:0] dout;
    logic [CH-1:0] ovf;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  // Reference model state (default-width DUT).
  int            m_acc[CH], m_i1[CH], m_i2[CH];
  logic [CH-1:0] m_dout = '0, m_ovf = '0;
  logic          m_mode = 1'b0;
  logic [15:0]   m_lfsr = 16'hACE1;
  logic [W-1:0]  m_act[CH], m_sh[CH];
  logic          m_full = 1'b0;
  int            n_accept;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int clampv(input int v, inout bit hit);
    if (v > LIM) begin hit = 1'b1; return LIM; end
    if (v < -LIM) begin hit = 1'b1; return -LIM; end
    return v;
  endfunction

  function automatic logic [CH*W-1:0] pk(input logic [W-1:0] s0, input logic [W-1:0] s1);
    return {s1, s0};
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic a,
                            input logic [CH*W-1:0] dv, input logic md,
                            input logic dt, input logic cl);
    int            x, fb, dd, sum;
    bit            hit;
    logic [CH-1:0] set;
    set = '0;
    if (r) begin
      for (int c = 0; c < CH; c++) begin
        m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; m_act[c] = 12'h800;
      end
      m_dout = '0; m_ovf = '0; m_mode = 1'b0; m_lfsr = 16'hACE1; m_full = 1'b0;
      return;
    end
    if (e) begin
      if (md != m_mode) begin
        m_mode = md;
        for (int c = 0; c < CH; c++) begin m_acc[c] = 0; m_i1[c] = 0; m_i2[c] = 0; end
        m_dout = '0;
      end else begin
        for (int c = 0; c < CH; c++) begin
          if (!m_mode) begin
            sum       = int'(m_act[c]) + (m_acc[c] % 4096);
            m_acc[c]  = sum;
            m_dout[c] = (sum >= 4096);
          end else begin
            hit       = 1'b0;
            x         = int'(m_act[c]) - H;
            fb        = m_dout[c] ? H : -H;
            dd        = dt ? int'((m_lfsr >> (c * D)) & 16'h3) - 2 : 0;
            m_i1[c]   = clampv(m_i1[c] + x + dd - fb, hit);
            m_i2[c]   = clampv(m_i2[c] + m_i1[c] - fb, hit);
            m_dout[c] = (m_i2[c] >= 0);
            set[c]    = hit;
          end
        end
      end
      m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
      if (m_full) m_act = m_sh;
    end
    m_ovf = (m_ovf & ~{CH{cl}}) | set;
    if (a) begin
      for (int c = 0; c < CH; c++) m_sh[c] = dv[c*W +: W];
      m_full = 1'b1;
    end else if (e) begin
      m_full = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, check ready, advance the model, then sit 1 ns past the edge.
  task automatic step(input logic r, input logic e, input logic v, input logic [CH*W-1:0] dv,
                      input logic md, input logic dt, input logic cl, output logic accepted);
    logic rdy;
    rst = r; en = e; din_valid = v; din = dv; mode = md; dither_en = dt; ovf_clr = cl;
    #1;
    rdy = ~m_full | e;
    check("din_ready", din_ready, rdy);
    accepted = v & rdy & ~r;
    if (accepted) n_accept++;
    model_edge(r, e, v & rdy, dv, md, dt, cl);
    if (e || r) sb.push_back('{m_dout, m_ovf});
    @(posedge clk_fast);
    #1;
  endtask

  // Monitor: after every tick or reset edge the DUT presents new outputs.
  logic last_tick = 1'b0;
  always @(posedge clk_fast) last_tick <= en | rst;

  always @(negedge clk_fast) begin
    if (last_tick === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_underflow: got empty queue, expected a pending entry at %0t", $time);
      end else begin
        mon_e = sb.pop_front();
        check("sb_dout", dout, mon_e.dout);
        check("sb_ovf", ovf, mon_e.ovf);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic a;
    int   ones, pat_bad, idx, n_tick;
    bit   found;
    rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0; mode = 1'b0; dither_en = 1'b0; ovf_clr = 1'b0;

    step(1, 1, 0, '0, 0, 0, 0, a);
    step(1, 1, 0, '0, 0, 0, 0, a);
    check("rst_dout", dout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_ready", din_ready, 1);

    // 1st order, s=0x400 from zero state: 0001 repeating.
    step(0, 0, 1, pk(12'h400, 12'h400), 0, 0, 0, a);
    step(0, 1, 0, '0, 1, 0, 0, a);
    step(0, 1, 0, '0, 0, 0, 0, a);
    check("t1_cleared", dout, 0);
    ones = 0; pat_bad = 0;
    for (int k = 0; k < 4096; k++) begin
      step(0, 1, 0, '0, 0, 0, 0, a);
      ones += int'(dout[0]);
      if (dout[0] !== (k % 4 == 3)) pat_bad++;
    end
    check("t1_ones", ones, 1024);
    check("t1_period4_errors", pat_bad, 0);

    // 2nd order, s=0xC00 without dither, then mid-scale.
    step(0, 0, 1, pk(12'hC00, 12'hC00), 1, 0, 0, a);
    step(0, 1, 0, '0, 1, 0, 0, a);
    ones = 0;
    for (int k = 0; k < 4096; k++) begin
      step(0, 1, 0, '0, 1, 0, 0, a);
      ones += int'(dout[0]);
    end
    check_range("t2_ones_c00", ones, 3070, 3074);
    check("t2_ovf_c00", ovf, 0);
    step(0, 0, 1, pk(12'h800, 12'h800), 1, 0, 0, a);
    step(0, 1, 0, '0, 1, 0, 0, a);
    ones = 0;
    for (int k = 0; k < 1024; k++) begin
      step(0, 1, 0, '0, 1, 0, 0, a);
      ones += int'(dout[0]);
    end
    check_range("t2_ones_800", ones, 509, 515);
    check("t2_ovf_800", ovf, 0);

    // Handshake: valid always high, tick every 4th cycle, incrementing samples.
    n_accept = 0; n_tick = 0; idx = 0;
    for (int k = 0; k < 48; k++) begin
      logic e;
      e = (k % 4 == 3);
      if (e) n_tick++;
      step(0, e, 1, pk(W'(256 + idx * 16), W'(3840 - idx * 16)), 1, 0, 0, a);
      if (a) idx++;
    end
    check("t3_accepts", n_accept, n_tick + 1);

    // Mode toggles mid-stream.
    step(0, 1, 0, '0, 0, 0, 0, a);
    check("t5_to1st_clear", dout, 0);
    step(0, 1, 0, '0, 0, 0, 0, a);
    check("t5_1st_from_zero", dout, 0);
    step(0, 1, 0, '0, 1, 1, 0, a);
    check("t5_to2nd_clear", dout, 0);
    step(0, 1, 0, '0, 1, 1, 0, a);
    check("t5_2nd_from_zero", dout, 2'b11);
    for (int k = 0; k < 64; k++) step(0, 1, 0, '0, 1, 1, 0, a);

    // Saturation on the narrow-integrator instance.
    step(1, 1, 0, '0, 0, 0, 0, a);
    check("t4_rst_ovf", ovf_g, 0);
    step(0, 0, 1, pk(12'hFFF, 12'hFFF), 0, 0, 0, a);
    step(0, 1, 0, '0, 1, 0, 0, a);
    found = 1'b0;
    for (int k = 0; k < 16 && !found; k++) begin
      step(0, 1, 0, '0, 1, 0, 0, a);
      if (ovf_g === 2'b11) found = 1'b1;
    end
    check("t4_ovf_rise", found, 1);
    step(0, 1, 0, '0, 1, 0, 1, a);
    check("t4_set_wins", ovf_g, 2'b11);
    step(0, 0, 1, pk(12'h800, 12'h800), 1, 0, 0, a);
    step(0, 1, 0, '0, 1, 0, 0, a);
    for (int k = 0; k < 8; k++) step(0, 1, 0, '0, 1, 0, 0, a);
    step(0, 0, 0, '0, 1, 0, 1, a);
    check("t4_cleared", ovf_g, 0);

    // Reset with a full shadow: the pending 0x111 must never be applied.
    step(0, 0, 1, pk(12'h111, 12'h111), 1, 0, 0, a);
    step(1, 1, 0, '0, 1, 0, 0, a);
    check("t6_dout", dout, 0);
    check("t6_ovf", ovf, 0);
    check("t6_ovf_g", ovf_g, 0);
    rst = 1'b0; en = 1'b0; din_valid = 1'b0;
    #1;
    check("t6_ready", din_ready, 1);
    for (int k = 0; k < 8; k++) begin
      step(0, 1, 0, '0, 0, 0, 0, a);
      check("t6_mid_scale", dout, (k % 2 == 1) ? 2'b11 : 2'b00);
    end
    step(0, 1, 0, '0, 1, 1, 0, a);
    for (int k = 0; k < 128; k++) step(0, 1, 0, '0, 1, 1, 0, a);

    step(0, 0, 0, '0, 1, 0, 0, a);
    step(0, 0, 0, '0, 1, 0, 0, a);
    check("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
